weight_buffer_loader: RTL

Write-side sequencer for the weight buffer. It accepts a load command (start row address, row count) and a valid/ready stream of DDR_DATA_LEN-bit DDR beats. It produces the `data_wr` / `wr_addr` / `wr_en` write port that the weight buffer consumes. Each buffer row spans BUFFER_NUM banks, so every row takes GROUPS consecutive beats, one bank group per beat. The loader sits between the DDR read DMA and the weight buffer.

---
 rtl/weight_buffer_loader_pkg.sv | 26 ++
 rtl/weight_buffer_loader_if.sv | 44 ++++
 rtl/weight_buffer_loader_group_decode.sv | 19 +
 rtl/weight_buffer_loader.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/weight_buffer_loader_pkg.sv
// Shared constants and FSM state type for the weight buffer write loader.
// Derived sizes are kept in step with the weight buffer bank geometry.
// No ports; imported by the interface, the group decoder and the loader top.
package weight_buffer_loader_pkg;

  localparam int X_PE           = 16;
  localparam int X_MESH         = 16;
  localparam int ADDR_LEN       = 16;
  localparam int DATA_LEN       = 64;
  localparam int DDR_DATA_LEN   = 256;

  // Bank geometry: one buffer row is BUFFER_NUM banks wide, and each DDR beat
  // fills BANKS_PER_WORD adjacent banks, so a row takes GROUPS beats.
  localparam int BUFFER_NUM     = 8 * X_PE * X_MESH / DATA_LEN;
  localparam int BANKS_PER_WORD = DDR_DATA_LEN / DATA_LEN;
  localparam int GROUPS         = BUFFER_NUM / BANKS_PER_WORD;
  localparam int LEN_W          = ADDR_LEN + 1;
  localparam int GRP_W          = $clog2(GROUPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } wbl_state_e;

endpackage

// File: rtl/weight_buffer_loader_if.sv
// Command, DDR beat stream and buffer write port bundle for the loader.
// Ports: cmd_valid/cmd_ready/cmd_addr/cmd_len, s_data/s_valid/s_ready,
//        data_wr/wr_addr/wr_en, busy/done, err_wrap (only with WBL_WRAP_CHK_EN).
interface weight_buffer_loader_if;
  import weight_buffer_loader_pkg::*;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [ADDR_LEN-1:0]     cmd_addr;
  logic [LEN_W-1:0]        cmd_len;

  logic [DDR_DATA_LEN-1:0] s_data;
  logic                    s_valid;
  logic                    s_ready;

  logic [DDR_DATA_LEN-1:0] data_wr;
  logic [ADDR_LEN-1:0]     wr_addr;
  logic [BUFFER_NUM-1:0]   wr_en;

  logic                    busy;
  logic                    done;
`ifdef WBL_WRAP_CHK_EN
  logic                    err_wrap;
`endif

  // Driver side: issues commands and beats, observes the write port.
  modport master (
    output cmd_valid, cmd_addr, cmd_len, s_data, s_valid,
    input  cmd_ready, s_ready, data_wr, wr_addr, wr_en, busy, done
`ifdef WBL_WRAP_CHK_EN
    , input err_wrap
`endif
  );

  // Loader side.
  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, s_data, s_valid,
    output cmd_ready, s_ready, data_wr, wr_addr, wr_en, busy, done
`ifdef WBL_WRAP_CHK_EN
    , output err_wrap
`endif
  );

endinterface

// File: rtl/weight_buffer_loader_group_decode.sv
// Purpose: expand a beat group index into the one-hot bank-group write enable.
// Latency: purely combinational, registered by the parent.
// Backpressure: none; stateless decoder.
// Ports: grp (group index in), grp_en (BUFFER_NUM-bit enable, BANKS_PER_WORD bits set).
module wbl_group_decode
  import weight_buffer_loader_pkg::*;
(
  input  logic [GRP_W-1:0]      grp,
  output logic [BUFFER_NUM-1:0] grp_en
);

  always_comb begin
    grp_en = '0;
    for (int g = 0; g < GROUPS; g++) begin
      grp_en[g*BANKS_PER_WORD +: BANKS_PER_WORD] = {BANKS_PER_WORD{grp == GRP_W'(g)}};
    end
  end

endmodule

// File: rtl/weight_buffer_loader.sv
// Purpose: write-side sequencer turning a row load command plus DDR beats into buffer writes.
// Latency: a beat accepted in cycle t is on wr_en/data_wr/wr_addr in cycle t+1; 1 beat/cycle.
// Backpressure: s_ready only in LOAD; cmd_ready only in IDLE (no command queueing).
// Ports: clk, rst_n (synchronous, active-low), bus (weight_buffer_loader_if.slave):
//   command (cmd_*), beat stream (s_*), write port (data_wr/wr_addr/wr_en), busy, done,
//   err_wrap when WBL_WRAP_CHK_EN is defined (sticky row-address wrap flag).
module weight_buffer_loader
  import weight_buffer_loader_pkg::*;
(
  input logic                   clk,
  input logic                   rst_n,
  weight_buffer_loader_if.slave bus
);

  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS - 1);

  wbl_state_e              state_q, state_d;
  logic [GRP_W-1:0]        grp_q, grp_d;
  logic [ADDR_LEN-1:0]     cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]        rows_left_q, rows_left_d;
  logic [DDR_DATA_LEN-1:0] data_wr_q, data_wr_d;
  logic [ADDR_LEN-1:0]     wr_addr_q, wr_addr_d;
  logic [BUFFER_NUM-1:0]   wr_en_q, wr_en_d;
  logic                    done_q, done_d;
  logic [BUFFER_NUM-1:0]   grp_en;

  wbl_group_decode u_group_decode (
    .grp    (grp_q),
    .grp_en (grp_en)
  );

`ifdef WBL_WRAP_CHK_EN
  localparam int SUM_W = ADDR_LEN + 2;
  logic             err_wrap_q, err_wrap_d;
  logic [SUM_W-1:0] wrap_sum;
  logic             wrap_hit;

  // Last row written is cmd_addr+cmd_len-1; anything past 2^ADDR_LEN-1 wraps.
  always_comb begin
    wrap_sum = SUM_W'(bus.cmd_addr) + SUM_W'(bus.cmd_len);
    wrap_hit = wrap_sum > SUM_W'(2 ** ADDR_LEN);
  end
`endif

  // Handshake readies are gated by rst_n so nothing is taken while reset is held.
  assign bus.cmd_ready = rst_n && (state_q == IDLE);
  assign bus.s_ready   = rst_n && (state_q == LOAD);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.data_wr   = data_wr_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_en     = wr_en_q;
`ifdef WBL_WRAP_CHK_EN
  assign bus.err_wrap  = err_wrap_q;
`endif

  always_comb begin
    state_d     = state_q;
    grp_d       = grp_q;
    cur_addr_d  = cur_addr_q;
    rows_left_d = rows_left_q;
    data_wr_d   = data_wr_q;
    wr_addr_d   = wr_addr_q;
    wr_en_d     = '0;
    done_d      = 1'b0;
`ifdef WBL_WRAP_CHK_EN
    err_wrap_d  = err_wrap_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          cur_addr_d  = bus.cmd_addr;
          rows_left_d = bus.cmd_len;
          grp_d       = '0;
`ifdef WBL_WRAP_CHK_EN
          err_wrap_d  = wrap_hit;
`endif
          if (bus.cmd_len == '0) begin
            // Empty command: complete immediately, no writes.
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (bus.s_valid) begin
          data_wr_d = bus.s_data;
          wr_addr_d = cur_addr_q;
          wr_en_d   = grp_en;
          if (grp_q == GRP_LAST) begin
            grp_d       = '0;
            cur_addr_d  = cur_addr_q + 1'b1;
            rows_left_d = rows_left_q - 1'b1;
            // done is registered alongside the final write so both land together.
            if (rows_left_q == LEN_W'(1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            grp_d = grp_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grp_q       <= '0;
      cur_addr_q  <= '0;
      rows_left_q <= '0;
      data_wr_q   <= '0;
      wr_addr_q   <= '0;
      wr_en_q     <= '0;
      done_q      <= 1'b0;
`ifdef WBL_WRAP_CHK_EN
      err_wrap_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      cur_addr_q  <= cur_addr_d;
      rows_left_q <= rows_left_d;
      data_wr_q   <= data_wr_d;
      wr_addr_q   <= wr_addr_d;
      wr_en_q     <= wr_en_d;
      done_q      <= done_d;
`ifdef WBL_WRAP_CHK_EN
      err_wrap_q  <= err_wrap_d;
`endif
    end
  end

endmodule
